// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_decoder
// Brief    : Quadrature A/B decoder: sync + deglitch both phases, decode Gray
//            transitions into step-enable / up_down for updown_counter.
// Revision : 1.0  initial release
// ============================================================================
module quad_decoder #(
    parameter int FILTER_LEN = 3,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr_err,
    output logic             enable,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int c_FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_INIT_W = $clog2(FILTER_LEN + 2);
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FILTER_LEN - 1);
    localparam logic [c_INIT_W-1:0] c_INIT_LOAD = c_INIT_W'(FILTER_LEN + 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Bit 1 carries phase A, bit 0 phase B, so vectors read as {a,b}.
    logic [1:0]          w_raw;
    logic [1:0]          r_sync1;
    logic [1:0]          r_sync2;
    logic [1:0]          r_filt;
    logic [1:0]          r_prev;
    logic [c_INIT_W-1:0] r_init_cnt;
    logic                w_init;
    logic                w_step;
    logic                w_dir;
    logic                w_illegal;
    logic [1:0]          w_delta;

    assign w_raw  = {enc_a, enc_b};
    assign w_init = (r_state == ST_INIT);

    generate
        for (genvar i = 0; i < 2; i++) begin : g_phase
            logic [c_FCNT_W-1:0] r_fcnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1[i] <= 1'b0;
                    r_sync2[i] <= 1'b0;
                    r_filt[i]  <= 1'b0;
                    r_fcnt     <= '0;
                end else begin
                    r_sync1[i] <= w_raw[i];
                    r_sync2[i] <= r_sync1[i];
                    if (w_init) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt    <= '0;
                    end else if (r_sync2[i] == r_filt[i]) begin
                        r_fcnt <= '0;
                    end else if (r_fcnt == c_FCNT_LAST) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt    <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Position along the forward cycle 00->10->11->01; a +1 step is forward,
    // -1 is reverse and +2 means both phases moved at once.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        case (g)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    assign w_delta = gray_pos(r_filt) - gray_pos(r_prev);

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_dir       = up_down;
        w_illegal   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                case (w_delta)
                    2'd1: begin
                        w_step = 1'b1;
                        w_dir  = 1'b1;
                    end
                    2'd3: begin
                        w_step = 1'b1;
                        w_dir  = 1'b0;
                    end
                    2'd2:    w_illegal = 1'b1;
                    default: w_step    = 1'b0;
                endcase
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= c_INIT_LOAD;
            r_prev     <= 2'b00;
            enable     <= 1'b0;
            up_down    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_init) begin
                r_init_cnt <= r_init_cnt - 1'b1;
                r_prev     <= r_filt;
                enable     <= 1'b0;
            end else begin
                r_prev <= r_filt;
                enable <= w_step;
                if (w_step) begin
                    up_down <= w_dir;
                end
            end
        end
    end

    // A decoded illegal transition overrides a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (w_illegal) begin
            err <= 1'b1;
            if (clr_err) begin
                err_cnt <= ERR_W'(1);
            end else if (!(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else if (clr_err) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_decoder
// Brief    : Directed bench for quad_decoder with an expected-pulse scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_quad_decoder;

    localparam int FILTER_LEN = 3;
    localparam int ERR_W      = 4;
    localparam int c_LAT      = FILTER_LEN + 3;

    logic             clk;
    logic             rst_n;
    logic             enc_a;
    logic             enc_b;
    logic             clr_err;
    logic             enable;
    logic             up_down;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    quad_decoder #(
        .FILTER_LEN (FILTER_LEN),
        .ERR_W      (ERR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .clr_err (clr_err),
        .enable  (enable),
        .up_down (up_down),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [3:0] cnt_model = 4'h0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter model stands in for updown_counter driven by the decoder.
    always @(negedge clk) begin
        logic exp_en;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missed_pulse_cyc", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        exp_en = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (enable === 1'b1 || exp_en) begin
            check("enable_at_cycle", {31'd0, enable}, {31'd0, exp_en});
            if (exp_en) begin
                check("up_down_on_step", {31'd0, up_down}, {31'd0, exp_q[0].dir});
                void'(exp_q.pop_front());
            end
        end
        if (enable === 1'b1) begin
            cnt_model = up_down ? cnt_model + 4'h1 : cnt_model - 4'h1;
        end
    end

    task automatic drive(input logic a, input logic b, input bit push, input logic dir);
        exp_t e;
        @(posedge clk);
        #1;
        enc_a = a;
        enc_b = b;
        if (push) begin
            e.cyc = cyc + c_LAT;
            e.dir = dir;
            exp_q.push_back(e);
        end
    endtask

    // One input change followed by the idle gap, leaving time 2 after an edge.
    task automatic step(input logic a, input logic b, input bit push, input logic dir);
        drive(a, b, push, dir);
        repeat (9) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n0;
        logic [ERR_W-1:0] exp_cnt;
        rst_n   = 1'b0;
        enc_a   = 1'b1;
        enc_b   = 1'b1;
        clr_err = 1'b0;

        // Reset held with both phases high
        idle(3);
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_up_down", {31'd0, up_down}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(20);
        check("init11_err", {31'd0, err}, 32'd0);
        check("init11_up_down", {31'd0, up_down}, 32'd1);

        // Re-reset with phases at 00 as the forward starting point
        @(posedge clk); #1; rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
        idle(2);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(20);
        cnt_model = 4'h7;

        // Forward 00->10->11->01->00
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("fwd_count", {28'd0, cnt_model}, 32'hB);
        check("fwd_up_down", {31'd0, up_down}, 32'd1);

        // Reverse 00->01->11->10
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("rev_count", {28'd0, cnt_model}, 32'h8);
        check("rev_up_down", {31'd0, up_down}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // 2-cycle glitch on A is filtered out
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1; enc_a = 1'b0;
        idle(12);
        check("glitch_err", {31'd0, err}, 32'd0);
        check("glitch_count", {28'd0, cnt_model}, 32'h7);

        // 3-cycle pulse on A: forward step then reverse step back
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        check("pulse3_count", {28'd0, cnt_model}, 32'h7);

        // Illegal 00->11, then 16 more illegal toggles saturating the count
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_err_cnt", {28'd0, err_cnt}, 32'd1);
        exp_cnt = 4'd1;
        for (int k = 0; k < 16; k++) begin
            step(~enc_a, ~enc_b, 1'b0, 1'b0);
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            check("illegal_sat_cnt", {28'd0, err_cnt}, {28'd0, exp_cnt});
        end
        check("illegal_up_down_held", {31'd0, up_down}, 32'd0);

        // Plain clear
        @(posedge clk); #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        #1;
        check("clr_err_flag", {31'd0, err}, 32'd0);
        check("clr_err_cnt", {28'd0, err_cnt}, 32'd0);
        idle(3);
        check("clr_err_cnt_hold", {28'd0, err_cnt}, 32'd0);

        // Clear coincident with an illegal decode: illegal wins (11->00)
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (c_LAT - 1) @(posedge clk);
        #1; clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        idle(3);
        check("clr_vs_illegal_err", {31'd0, err}, 32'd1);
        check("clr_vs_illegal_cnt", {28'd0, err_cnt}, 32'd1);

        // Reset pulse while enable is high
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n0 = cyc;
        repeat (c_LAT) @(posedge clk);
        #1;
        check("pre_rst_enable", {31'd0, enable}, 32'd1);
        check("pre_rst_cycle", cyc, n0 + c_LAT);
        rst_n = 1'b0;
        #1;
        check("async_rst_enable", {31'd0, enable}, 32'd0);
        check("async_rst_up_down", {31'd0, up_down}, 32'd1);
        check("async_rst_err", {31'd0, err}, 32'd0);
        check("async_rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        idle(20);
        check("post_rst_up_down", {31'd0, up_down}, 32'd1);
        check("post_rst_err", {31'd0, err}, 32'd0);

        // Decoding resumes normally: 11->01 forward
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(4);
        check("pending_pulses", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
